// File: rtl/stage_fetch_pkg.sv
// rtl/stage_fetch_pkg.sv - shared fetch/decode types and constants
package stage_fetch_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] pc_t;

  localparam word_t NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_STALL = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_t;

  // Word-align an address by forcing the byte offset to zero.
  function automatic pc_t align_pc(input pc_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// rtl/fetch_skid.sv - one-entry skid register for the fetch stage
module fetch_skid
  import stage_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_ir,
  input  logic        byp_valid,
  input  logic [31:0] byp_pc,
  input  logic [31:0] byp_ir,
  output logic        held,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_ir
);

  logic        held_r;
  logic [31:0] pc_r;
  logic [31:0] ir_r;

  // Capture a word that returned while decode was stalled; clear wins over load.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      held_r <= 1'b0;
      pc_r   <= '0;
      ir_r   <= NOP_INSTR;
    end else if (load) begin
      held_r <= 1'b1;
      pc_r   <= load_pc;
      ir_r   <= load_ir;
    end
  end

  // A held entry is older than the live memory response, so it is presented first.
  always_comb begin
    held      = held_r;
    out_valid = held_r ? 1'b1 : byp_valid;
    out_pc    = held_r ? pc_r : byp_pc;
    out_ir    = held_r ? ir_r : byp_ir;
  end

endmodule

// File: rtl/stage_fetch.sv
// rtl/stage_fetch.sv - instruction fetch stage feeding the decoder
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        jmp_valid_i,
  input  logic [31:0] jmp_addr_i,
  input  logic        halt_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  localparam pc_t RESET_PC = align_pc(RESET_VECTOR);

  fetch_state_t state_r, state_next;

  pc_t         pc_r, pc_next;
  logic        resp_valid_r, resp_valid_next;
  pc_t         resp_pc_r;
  logic        last_valid_r;
  word_t       last_ir_r;
  pc_t         last_pc_r;

  pc_t         jmp_target;
  logic        jump_take;
  logic        halting;
  logic        skid_load, skid_clr, skid_held;
  logic        sel_valid;
  logic [31:0] sel_pc, sel_ir;
  word_t       byp_ir;

  assign jmp_target = align_pc(jmp_addr_i);
  assign halting    = halt_i || (state_r == FS_HALT);
  assign jump_take  = jmp_valid_i && !halting;
  assign byp_ir     = resp_valid_r ? imem_data_i : NOP_INSTR;

  fetch_skid u_skid (
    .clk       (clk_i),
    .reset     (reset_i),
    .clr       (skid_clr),
    .load      (skid_load),
    .load_pc   (resp_pc_r),
    .load_ir   (imem_data_i),
    .byp_valid (resp_valid_r),
    .byp_pc    (resp_pc_r),
    .byp_ir    (byp_ir),
    .held      (skid_held),
    .out_valid (sel_valid),
    .out_pc    (sel_pc),
    .out_ir    (sel_ir)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= FS_RUN;
    else         state_r <= state_next;
  end

  // Next state: halt is sticky, a jump always lands in RUN, otherwise follow stall.
  always_comb begin
    state_next = state_r;
    case (state_r)
      FS_HALT: state_next = FS_HALT;
      default: begin
        if (halt_i)         state_next = FS_HALT;
        else if (jump_take) state_next = FS_RUN;
        else if (stall_i)   state_next = FS_STALL;
        else                state_next = FS_RUN;
      end
    endcase
  end

  // Fetch address, PC update and skid control. Only words issued in RUN without a
  // redirect are kept; a jump re-issues the target so its word arrives two cycles on.
  always_comb begin
    imem_addr_o     = pc_r;
    pc_next         = pc_r;
    resp_valid_next = 1'b0;
    skid_load       = 1'b0;
    skid_clr        = 1'b0;
    if (reset_i) begin
      imem_addr_o = RESET_PC;
    end else begin
      if (jump_take) imem_addr_o = jmp_target;
      if (halting)                pc_next = pc_r;
      else if (jump_take)         pc_next = jmp_target;
      else if (state_r == FS_RUN) pc_next = pc_r + 32'd4;
      resp_valid_next = (state_r == FS_RUN) && !halt_i && !jump_take;
      skid_load       = (state_r == FS_STALL) && resp_valid_r && !halting && !jump_take;
      skid_clr        = halting || jump_take || ((state_r == FS_RUN) && skid_held);
    end
  end

  // Decode-facing outputs: RUN shows skid-or-live word, STALL repeats, HALT emits bubbles.
  always_comb begin
    valid_o = 1'b0;
    ir_o    = NOP_INSTR;
    pc_o    = last_pc_r;
    if (reset_i) begin
      pc_o = '0;
    end else begin
      case (state_r)
        FS_RUN: begin
          valid_o = sel_valid;
          ir_o    = sel_valid ? sel_ir : NOP_INSTR;
          pc_o    = sel_valid ? sel_pc : last_pc_r;
        end
        FS_STALL: begin
          valid_o = last_valid_r;
          ir_o    = last_ir_r;
          pc_o    = last_pc_r;
        end
        default: ;
      endcase
    end
  end

  // PC, in-flight response tag and the copy of what decode saw last cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_r         <= RESET_PC;
      resp_valid_r <= 1'b0;
      resp_pc_r    <= '0;
      last_valid_r <= 1'b0;
      last_ir_r    <= NOP_INSTR;
      last_pc_r    <= '0;
    end else begin
      pc_r         <= pc_next;
      resp_valid_r <= resp_valid_next;
      resp_pc_r    <= imem_addr_o;
      last_valid_r <= valid_o;
      last_ir_r    <= ir_o;
      last_pc_r    <= pc_o;
    end
  end

endmodule
